riscv_tag_check_unit: RTL and testbench
=======================================

Name: riscv_tag_check_unit

Overview:
Parametrised DIFT tag-check unit covering all tag-propagating instruction classes: LOAD, STORE, ALU and JUMP. It generalises single-bit, load-only checking to TAG_WIDTH-bit tags with a programmable tag mask. It also adds a registered exception request that is held until the controller acknowledges it, stalls upstream while an exception is pending, and keeps a saturating violation counter. It sits between the ID/EX tag datapath and the exception controller.

Parameters:
TAG_WIDTH, 4, bits per operand tag (minimum 1).
COUNT_WIDTH, 16, width of the violation counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
valid_i  input  1  check request valid.
ready_o  output  1  unit can accept a request.
op_class_i  input  2  instruction class: 0 LOAD, 1 STORE, 2 ALU, 3 JUMP.
pc_i  input  32  PC of the checked instruction.
src_tag_i  input  TAG_WIDTH  source data tag.
addr_tag_i  input  TAG_WIDTH  source address / RS1 tag.
dest_tag_i  input  TAG_WIDTH  destination tag.
tag_mask_i  input  TAG_WIDTH  tag bits that are eligible to trigger a check.
tcr_i  input  32  Tag Check Register.
flush_i  input  1  pipeline flush; drops a pending request.
exc_req_o  output  1  tag-check exception request.
exc_ack_i  input  1  controller acknowledge.
exc_cause_o  output  3  hit vector {D, SA, S}.
exc_class_o  output  2  class of the offending instruction.
exc_pc_o  output  32  PC of the offending instruction.
viol_cnt_o  output  COUNT_WIDTH  violation count.
cnt_clr_i  input  1  synchronous counter clear.

Behaviour:
- Reset values: exc_req_o=0, exc_cause_o=0, exc_class_o=0, exc_pc_o=0, viol_cnt_o=0, ready_o=1. Reset mid-PENDING returns to IDLE immediately.
- TCR layout: class k uses bit 3k for S, bit 3k+1 for SA, bit 3k+2 for D. Bits 12..31 are ignored.
- Hit vector is computed combinationally from the inputs:
  - hit_s  = |(src_tag_i & tag_mask_i) & tcr[3k]
  - hit_sa = |(addr_tag_i & tag_mask_i) & tcr[3k+1]
  - hit_d  = |(dest_tag_i & tag_mask_i) & tcr[3k+2]
  - k is op_class_i. tcr_i and tag_mask_i are sampled only at acceptance.
- Acceptance: a request is accepted on a cycle where valid_i && ready_o. ready_o = (state==IDLE).
- FSM, states IDLE and PENDING:
  - IDLE: on acceptance with hit!=0, register cause/class/pc and go to PENDING next edge. exc_req_o=1 in the cycle after acceptance (latency 1). Accepted with hit==0: stay IDLE; outputs unchanged.
  - PENDING: exc_req_o=1. exc_cause_o, exc_class_o and exc_pc_o are stable. exc_ack_i or flush_i returns to IDLE next edge; ready_o=1 from that cycle. Ack and flush in the same cycle behave as a single release.
  - While PENDING, valid_i is ignored. Upstream must hold the request.
  - Ack while IDLE: ignored.
  - flush_i in IDLE: no effect; a same-cycle acceptance still proceeds.
- exc_cause_o, exc_class_o and exc_pc_o retain their last values after release; they are only meaningful while exc_req_o=1.
- Counter: increments by 1 on each acceptance with hit!=0. It does not count hit bits.
  - Saturates at 2^COUNT_WIDTH-1.
  - cnt_clr_i has priority over a same-cycle increment; result is 0.
  - A flushed violation remains counted.

Optional Feature:
TAG_CHECK_CNT_EN:
- Defined: violation counter present as specified.
- Undefined: counter logic removed, viol_cnt_o tied to 0, cnt_clr_i ignored. Port list is unchanged.

Decomposition:
- Package riscv_defines gets:
  - class encodings TAG_CLASS_LOAD/STORE/ALU/JUMP;
  - TCR offsets TAG_CHK_S_OFS=0, TAG_CHK_SA_OFS=1, TAG_CHK_D_OFS=2 and TAG_CHK_STRIDE=3;
  - FSM enum tag_chk_state_e {TC_IDLE, TC_PENDING}.
- One sub-module: riscv_tag_check_hit, a purely combinational per-class hit-vector computation. It is instantiated once.

Test Plan:
- LOAD, src_tag=4'b0010, mask=4'hF, tcr[0]=1, pc=0x100 -> exc_req_o=1 the cycle after acceptance, cause=3'b001, class=0, pc=0x100, ready_o=0, viol_cnt_o=1.
- STORE, dest_tag=4'b1000, mask=4'h7, tcr[5]=1 -> no exception, ready_o stays 1, count unchanged. Same stimulus with mask=4'hF -> cause=3'b100.
- PENDING with a new valid_i held 3 cycles, then exc_ack_i -> second request accepted the cycle after release. The request is checked against the tcr_i value present at acceptance.
- exc_ack_i and flush_i in the same cycle in PENDING -> one return to IDLE, no spurious re-request, count incremented once only.
- COUNT_WIDTH=2, five violations -> viol_cnt_o saturates at 3. cnt_clr_i together with a violation -> viol_cnt_o=0.
- rst asserted asynchronously in PENDING -> exc_req_o=0 and ready_o=1 without a clock edge. Build without TAG_CHECK_CNT_EN -> viol_cnt_o=0 throughout.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared encodings for the DIFT tag-check unit: instruction classes,
// Tag Check Register field offsets and the check FSM states.
package riscv_defines;

    // Instruction classes that propagate tags
    localparam logic [1:0] TAG_CLASS_LOAD  = 2'd0;
    localparam logic [1:0] TAG_CLASS_STORE = 2'd1;
    localparam logic [1:0] TAG_CLASS_ALU   = 2'd2;
    localparam logic [1:0] TAG_CLASS_JUMP  = 2'd3;

    // TCR: each class owns a 3-bit field {D, SA, S} at bit STRIDE*class
    localparam int TAG_CHK_S_OFS  = 0;
    localparam int TAG_CHK_SA_OFS = 1;
    localparam int TAG_CHK_D_OFS  = 2;
    localparam int TAG_CHK_STRIDE = 3;
    localparam int TAG_CHK_TCR_W  = 4 * TAG_CHK_STRIDE;

    typedef enum logic {
        TC_IDLE,
        TC_PENDING
    } tag_chk_state_e;

endpackage

// File: rtl/riscv_tag_check_hit.sv
// Combinational hit-vector computation {D, SA, S} for one instruction.
// The class picks its 3-bit enable field out of the live TCR bits.
module riscv_tag_check_hit
    import riscv_defines::*;
#(
    parameter int TAG_WIDTH = 4
) (
    input  logic [1:0]               op_class,
    input  logic [TAG_WIDTH-1:0]     src_tag,
    input  logic [TAG_WIDTH-1:0]     addr_tag,
    input  logic [TAG_WIDTH-1:0]     dest_tag,
    input  logic [TAG_WIDTH-1:0]     tag_mask,
    input  logic [TAG_CHK_TCR_W-1:0] tcr,
    output logic [2:0]               hit
);

    logic [TAG_CHK_STRIDE-1:0] cls_en;

    // Select the enable field belonging to the instruction class
    always_comb begin
        cls_en = '0;
        for (int k = 0; k < 4; k++) begin
            if (op_class == k[1:0])
                cls_en = tcr[k*TAG_CHK_STRIDE +: TAG_CHK_STRIDE];
        end
    end

    assign hit[0] = (|(src_tag  & tag_mask)) & cls_en[TAG_CHK_S_OFS];
    assign hit[1] = (|(addr_tag & tag_mask)) & cls_en[TAG_CHK_SA_OFS];
    assign hit[2] = (|(dest_tag & tag_mask)) & cls_en[TAG_CHK_D_OFS];

endmodule

// File: rtl/riscv_tag_check_unit.sv
// DIFT tag-check unit: checks LOAD/STORE/ALU/JUMP tags against the TCR,
// raises a held exception request until acknowledged or flushed, and
// stalls upstream while one is pending.
// Build option: define TAG_CHECK_CNT_EN to include the saturating
// violation counter; otherwise viol_cnt_o is tied to 0.
module riscv_tag_check_unit
    import riscv_defines::*;
#(
    parameter int TAG_WIDTH   = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [1:0]             op_class_i,
    input  logic [31:0]            pc_i,
    input  logic [TAG_WIDTH-1:0]   src_tag_i,
    input  logic [TAG_WIDTH-1:0]   addr_tag_i,
    input  logic [TAG_WIDTH-1:0]   dest_tag_i,
    input  logic [TAG_WIDTH-1:0]   tag_mask_i,
    input  logic [31:0]            tcr_i,
    input  logic                   flush_i,
    output logic                   exc_req_o,
    input  logic                   exc_ack_i,
    output logic [2:0]             exc_cause_o,
    output logic [1:0]             exc_class_o,
    output logic [31:0]            exc_pc_o,
    output logic [COUNT_WIDTH-1:0] viol_cnt_o,
    input  logic                   cnt_clr_i
);

    tag_chk_state_e state, state_nxt;
    logic [2:0]     hit;
    logic           accept;
    logic           violate;
    logic [31:0]    unused_tcr;

    // TCR bits above the four class fields carry no meaning here
    assign unused_tcr = {tcr_i[31:TAG_CHK_TCR_W], {TAG_CHK_TCR_W{1'b0}}};

    riscv_tag_check_hit #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_hit (
        .op_class (op_class_i),
        .src_tag  (src_tag_i),
        .addr_tag (addr_tag_i),
        .dest_tag (dest_tag_i),
        .tag_mask (tag_mask_i),
        .tcr      (tcr_i[TAG_CHK_TCR_W-1:0]),
        .hit      (hit)
    );

    assign accept  = valid_i && ready_o;
    assign violate = accept && (hit != 3'b000);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TC_IDLE;
        else     state <= state_nxt;
    end

    // Next state: enter PENDING on a violating acceptance; ack or flush
    // (alone or together) is a single release
    always_comb begin
        state_nxt = state;
        case (state)
            TC_IDLE:    if (violate) state_nxt = TC_PENDING;
            TC_PENDING: if (exc_ack_i || flush_i) state_nxt = TC_IDLE;
            default:    state_nxt = TC_IDLE;
        endcase
    end

    // Outputs decoded from state; requests only accepted from IDLE
    always_comb begin
        ready_o   = (state == TC_IDLE);
        exc_req_o = (state == TC_PENDING);
    end

    // Capture the offending instruction; held until the next violation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_cause_o <= '0;
            exc_class_o <= '0;
            exc_pc_o    <= '0;
        end else if (violate) begin
            exc_cause_o <= hit;
            exc_class_o <= op_class_i;
            exc_pc_o    <= pc_i;
        end
    end

`ifdef TAG_CHECK_CNT_EN
    // Saturating violation counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            viol_cnt_o <= '0;
        else if (cnt_clr_i)
            viol_cnt_o <= '0;
        else if (violate && (viol_cnt_o != {COUNT_WIDTH{1'b1}}))
            viol_cnt_o <= viol_cnt_o + COUNT_WIDTH'(1);
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign viol_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_riscv_tag_check_unit.sv
// Directed self-checking bench for riscv_tag_check_unit (COUNT_WIDTH=2 so
// saturation is reachable). Expected counts follow the TAG_CHECK_CNT_EN build.
module tb_riscv_tag_check_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_class_i = 2'd0;
    logic [31:0] pc_i = 32'h0;
    logic [3:0]  src_tag_i = 4'h0;
    logic [3:0]  addr_tag_i = 4'h0;
    logic [3:0]  dest_tag_i = 4'h0;
    logic [3:0]  tag_mask_i = 4'h0;
    logic [31:0] tcr_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        exc_req_o;
    logic        exc_ack_i = 1'b0;
    logic [2:0]  exc_cause_o;
    logic [1:0]  exc_class_o;
    logic [31:0] exc_pc_o;
    logic [1:0]  viol_cnt_o;
    logic        cnt_clr_i = 1'b0;

    int n_tot = 0;
    int n_bad = 0;

    riscv_tag_check_unit #(.TAG_WIDTH(4), .COUNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .op_class_i(op_class_i), .pc_i(pc_i), .src_tag_i(src_tag_i),
        .addr_tag_i(addr_tag_i), .dest_tag_i(dest_tag_i),
        .tag_mask_i(tag_mask_i), .tcr_i(tcr_i), .flush_i(flush_i),
        .exc_req_o(exc_req_o), .exc_ack_i(exc_ack_i),
        .exc_cause_o(exc_cause_o), .exc_class_o(exc_class_o),
        .exc_pc_o(exc_pc_o), .viol_cnt_o(viol_cnt_o), .cnt_clr_i(cnt_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected counter value for a given number of counted violations
    function automatic logic [31:0] ecnt(input int v);
`ifdef TAG_CHECK_CNT_EN
        return (v > 3) ? 32'd3 : 32'(v);
`else
        return (v > 3) ? 32'd0 : 32'd0 + 32'(v) * 32'd0;
`endif
    endfunction

    // One-cycle request presented on a negedge, withdrawn on the next
    task automatic req(input logic [1:0] op, input logic [3:0] s, input logic [3:0] a,
                       input logic [3:0] d, input logic [3:0] m, input logic [31:0] t,
                       input logic [31:0] pc);
        @(negedge clk);
        valid_i = 1'b1; op_class_i = op; src_tag_i = s; addr_tag_i = a;
        dest_tag_i = d; tag_mask_i = m; tcr_i = t; pc_i = pc;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic pulse_ack(input logic a, input logic f);
        @(negedge clk);
        exc_ack_i = a; flush_i = f;
        @(negedge clk);
        exc_ack_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_req",   32'(exc_req_o),   32'd0);
        chk("rst_rdy",   32'(ready_o),     32'd1);
        chk("rst_cause", 32'(exc_cause_o), 32'd0);
        chk("rst_class", 32'(exc_class_o), 32'd0);
        chk("rst_pc",    exc_pc_o,         32'd0);
        chk("rst_cnt",   32'(viol_cnt_o),  32'd0);
        @(negedge clk); rst = 1'b0;

        // LOAD, src hit
        req(2'd0, 4'b0010, 4'h0, 4'h0, 4'hF, 32'h1, 32'h100);
        chk("ld_req",   32'(exc_req_o),   32'd1);
        chk("ld_cause", 32'(exc_cause_o), 32'b001);
        chk("ld_class", 32'(exc_class_o), 32'd0);
        chk("ld_pc",    exc_pc_o,         32'h100);
        chk("ld_rdy",   32'(ready_o),     32'd0);
        chk("ld_cnt",   32'(viol_cnt_o),  ecnt(1));
        pulse_ack(1'b1, 1'b0);
        chk("ld_rel_req", 32'(exc_req_o), 32'd0);
        chk("ld_rel_rdy", 32'(ready_o),   32'd1);

        // STORE, dest tag masked off -> no exception
        req(2'd1, 4'h0, 4'h0, 4'b1000, 4'h7, 32'h20, 32'h200);
        chk("st_nohit_req", 32'(exc_req_o),  32'd0);
        chk("st_nohit_rdy", 32'(ready_o),    32'd1);
        chk("st_nohit_cnt", 32'(viol_cnt_o), ecnt(1));
        chk("st_nohit_pc",  exc_pc_o,        32'h100);
        // Same with full mask -> dest hit
        req(2'd1, 4'h0, 4'h0, 4'b1000, 4'hF, 32'h20, 32'h200);
        chk("st_req",   32'(exc_req_o),   32'd1);
        chk("st_cause", 32'(exc_cause_o), 32'b100);
        chk("st_class", 32'(exc_class_o), 32'd1);
        chk("st_cnt",   32'(viol_cnt_o),  ecnt(2));

        // New ALU request held 3 cycles while PENDING, TCR disabled meanwhile
        @(negedge clk);
        valid_i = 1'b1; op_class_i = 2'd2; src_tag_i = 4'h0; addr_tag_i = 4'b0001;
        dest_tag_i = 4'h0; tag_mask_i = 4'hF; tcr_i = 32'h0; pc_i = 32'h300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_req",   32'(exc_req_o),   32'd1);
            chk("hold_rdy",   32'(ready_o),     32'd0);
            chk("hold_pc",    exc_pc_o,         32'h200);
            chk("hold_cause", 32'(exc_cause_o), 32'b100);
        end
        // Release; enable ALU SA (bit 7) so the held request hits at acceptance
        exc_ack_i = 1'b1; tcr_i = 32'h80;
        @(negedge clk);
        exc_ack_i = 1'b0;
        chk("rel_req", 32'(exc_req_o), 32'd0);
        chk("rel_rdy", 32'(ready_o),   32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        chk("alu_req",   32'(exc_req_o),   32'd1);
        chk("alu_cause", 32'(exc_cause_o), 32'b010);
        chk("alu_class", 32'(exc_class_o), 32'd2);
        chk("alu_pc",    exc_pc_o,         32'h300);
        chk("alu_cnt",   32'(viol_cnt_o),  ecnt(3));

        // Ack and flush together -> single release, no re-request
        pulse_ack(1'b1, 1'b1);
        chk("af_req", 32'(exc_req_o), 32'd0);
        chk("af_rdy", 32'(ready_o),   32'd1);
        @(negedge clk);
        chk("af_req2", 32'(exc_req_o),  32'd0);
        chk("af_cnt",  32'(viol_cnt_o), ecnt(3));

        // Ack while IDLE is ignored
        pulse_ack(1'b1, 1'b0);
        chk("idle_ack_req", 32'(exc_req_o), 32'd0);
        chk("idle_ack_rdy", 32'(ready_o),   32'd1);

        // Flush in IDLE with same-cycle JUMP acceptance still proceeds
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; op_class_i = 2'd3; src_tag_i = 4'h0;
        addr_tag_i = 4'h0; dest_tag_i = 4'b0001; tag_mask_i = 4'hF;
        tcr_i = 32'hFFFF_F800; pc_i = 32'h400;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        chk("jmp_req",   32'(exc_req_o),   32'd1);
        chk("jmp_cause", 32'(exc_cause_o), 32'b100);
        chk("jmp_class", 32'(exc_class_o), 32'd3);
        chk("jmp_cnt",   32'(viol_cnt_o),  ecnt(4));
        // Flushed violation stays counted
        pulse_ack(1'b0, 1'b1);
        chk("fl_req", 32'(exc_req_o),  32'd0);
        chk("fl_cnt", 32'(viol_cnt_o), ecnt(4));

        // Fifth violation: counter stays saturated
        req(2'd0, 4'hF, 4'h0, 4'h0, 4'hF, 32'h1, 32'h500);
        chk("sat_cnt", 32'(viol_cnt_o), ecnt(5));
        pulse_ack(1'b1, 1'b0);

        // Clear together with a violation -> 0
        @(negedge clk);
        valid_i = 1'b1; cnt_clr_i = 1'b1; op_class_i = 2'd0; src_tag_i = 4'h1;
        tag_mask_i = 4'hF; tcr_i = 32'h1; pc_i = 32'h600;
        @(negedge clk);
        valid_i = 1'b0; cnt_clr_i = 1'b0;
        chk("clr_cnt", 32'(viol_cnt_o), 32'd0);
        chk("clr_req", 32'(exc_req_o),  32'd1);
        chk("clr_pc",  exc_pc_o,        32'h600);

        // Asynchronous reset while PENDING, sampled before any edge
        #2 rst = 1'b1;
        #1;
        chk("arst_req",   32'(exc_req_o),   32'd0);
        chk("arst_rdy",   32'(ready_o),     32'd1);
        chk("arst_pc",    exc_pc_o,         32'd0);
        chk("arst_cause", 32'(exc_cause_o), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(exc_req_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
